// File: rtl/serial_io_frame_scheduler.sv
// Frame sequencer for the step-line output chains and the limit-switch input chains.
// A single FSM owns the shared shift clock, so output and input shifting stay in lockstep.
module serial_io_frame_scheduler #(
  parameter int OUT_LINES  = 24,
  parameter int IN_LINES   = 6,
  parameter int CHAIN_BITS = 16,
  parameter int CLK_DIV    = 4,
  localparam int IDX_W     = (CHAIN_BITS > 1) ? $clog2(CHAIN_BITS) : 1
) (
  input  logic                 sys_clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 frame_req,
  output logic [IDX_W-1:0]     out_bit_idx,
  input  logic [OUT_LINES-1:0] out_bits,
  output logic                 in_wr,
  output logic [IDX_W-1:0]     in_bit_idx,
  output logic [IN_LINES-1:0]  in_bits,
  output logic [OUT_LINES-1:0] sdata,
  output logic                 shi,
  output logic                 sto,
  output logic                 lm_ld,
  output logic                 lm_ck,
  input  logic [IN_LINES-1:0]  lim_in,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] BIT_TOP = IDX_W'(CHAIN_BITS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, HIGH, STORE} state_t;

  state_t           state_reg, state_next;
  logic [PH_W-1:0]  phase_reg, phase_next;
  logic [IDX_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic             pending_reg, pending_next;
  logic             overrun_set;
  logic             phase_last;
  logic             start;
  logic             setup_last_next;

  assign phase_last      = (phase_reg == PH_LAST);
  assign start           = enable && (frame_req || pending_reg);
  assign setup_last_next = (state_next == SETUP) && (phase_next == PH_LAST);
  assign out_bit_idx     = bit_cnt_reg;

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      phase_reg   <= '0;
      bit_cnt_reg <= BIT_TOP;
      pending_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      phase_reg   <= phase_next;
      bit_cnt_reg <= bit_cnt_next;
      pending_reg <= pending_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    phase_next   = phase_reg;
    bit_cnt_next = bit_cnt_reg;
    pending_next = pending_reg;
    overrun_set  = 1'b0;

    // The last STORE cycle consumes a request directly as the next frame start.
    if ((state_reg != IDLE) && !((state_reg == STORE) && phase_last) && frame_req) begin
      if (pending_reg) overrun_set  = 1'b1;
      else             pending_next = 1'b1;
    end

    if (state_reg != IDLE) phase_next = phase_last ? '0 : phase_reg + 1'b1;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = LOAD;
          phase_next   = '0;
          bit_cnt_next = BIT_TOP;
          pending_next = 1'b0;
        end
      end
      LOAD:  if (phase_last) state_next = SETUP;
      SETUP: if (phase_last) state_next = HIGH;
      HIGH: begin
        if (phase_last) begin
          if (bit_cnt_reg == '0) begin
            state_next = STORE;
          end else begin
            bit_cnt_next = bit_cnt_reg - 1'b1;
            state_next   = SETUP;
          end
        end
      end
      STORE: begin
        if (phase_last) begin
          pending_next = 1'b0;
          if (start) begin
            state_next   = LOAD;
            bit_cnt_next = BIT_TOP;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pin levels are registered from the next state so they line up with it exactly.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      sdata      <= '0;
      shi        <= 1'b0;
      sto        <= 1'b0;
      lm_ck      <= 1'b0;
      lm_ld      <= 1'b1;
      in_wr      <= 1'b0;
      in_bit_idx <= '0;
      in_bits    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      shi        <= (state_next == HIGH);
      lm_ck      <= (state_next == HIGH);
      sto        <= (state_next == STORE);
      lm_ld      <= (state_next != LOAD);
      busy       <= (state_next != IDLE);
      frame_done <= (state_next == STORE) && (phase_next == PH_LAST);
      in_wr      <= setup_last_next;
      if (setup_last_next) begin
        in_bit_idx <= bit_cnt_next;
        in_bits    <= lim_in;
      end
      if ((state_reg == SETUP) && (phase_reg == '0)) sdata <= out_bits;
      if (overrun_set)      overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_io_frame_scheduler.sv
// Randomized bench: two scheduler instances (CLK_DIV 4 and 1) checked every cycle
// against a frame-timeline model derived from frame start times.
module tb_serial_io_frame_scheduler;

  localparam int OL = 24;
  localparam int IL = 6;
  localparam int CB = 16;
  localparam int IW = (CB > 1) ? $clog2(CB) : 1;

  logic clk;
  logic reset;
  logic enable;
  logic frame_req;
  logic overrun_clr;

  logic [OL-1:0] out_tab [CB];
  logic [IL-1:0] lim_tab [CB];

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int D = (gi == 0) ? 4 : 1;
    localparam int L = D * (2 * CB + 2);

    logic [IW-1:0] out_bit_idx, in_bit_idx;
    logic [OL-1:0] out_bits, sdata;
    logic [IL-1:0] lim_in, in_bits;
    logic          in_wr, shi, sto, lm_ld, lm_ck, busy, frame_done, overrun;

    // Regfile stand-ins; with CLK_DIV=1 the limit lines are held constant per table set.
    assign out_bits = out_tab[out_bit_idx];
    assign lim_in   = (D == 1) ? lim_tab[0] : lim_tab[out_bit_idx];

    serial_io_frame_scheduler #(
      .OUT_LINES(OL), .IN_LINES(IL), .CHAIN_BITS(CB), .CLK_DIV(D)
    ) dut (
      .sys_clock(clk), .reset(reset), .enable(enable), .frame_req(frame_req),
      .out_bit_idx(out_bit_idx), .out_bits(out_bits), .in_wr(in_wr),
      .in_bit_idx(in_bit_idx), .in_bits(in_bits), .sdata(sdata), .shi(shi),
      .sto(sto), .lm_ld(lm_ld), .lm_ck(lm_ck), .lim_in(lim_in), .busy(busy),
      .frame_done(frame_done), .overrun(overrun), .overrun_clr(overrun_clr)
    );

    string         pfx;
    int            cyc    = 0;
    int            fstart = -1;
    bit            pend   = 0;
    bit            ovr    = 0;
    bit            armed  = 0;
    int            e_idx  = CB - 1;
    logic [OL-1:0] e_sdata = '0;

    initial pfx = (D == 4) ? "div4 " : "div1 ";

    always @(negedge clk) begin
      int rel, j, sub;
      bit e_busy, e_ld, in_bitz, e_shi, e_wr, e_sto, e_done, last, ovr_set;
      rel     = (fstart >= 0) ? cyc - fstart : -1;
      e_busy  = (rel >= 0) && (rel < L);
      e_ld    = !(e_busy && rel < D);
      in_bitz = e_busy && (rel >= D) && (rel < D + 2 * D * CB);
      j       = in_bitz ? (rel - D) / (2 * D) : 0;
      sub     = in_bitz ? (rel - D) % (2 * D) : 0;
      e_shi   = in_bitz && (sub >= D);
      e_wr    = in_bitz && (sub == D - 1);
      e_sto   = e_busy && (rel >= D + 2 * D * CB);
      e_done  = e_busy && (rel == L - 1);
      if (e_busy && rel < D) e_idx = CB - 1;
      else if (in_bitz)      e_idx = CB - 1 - j;

      if (armed) begin
        check({pfx, "busy"}, busy, e_busy);
        check({pfx, "lm_ld"}, lm_ld, e_ld);
        check({pfx, "shi"}, shi, e_shi);
        check({pfx, "lm_ck"}, lm_ck, e_shi);
        check({pfx, "sto"}, sto, e_sto);
        check({pfx, "frame_done"}, frame_done, e_done);
        check({pfx, "in_wr"}, in_wr, e_wr);
        check({pfx, "overrun"}, overrun, ovr);
        check({pfx, "out_bit_idx"}, out_bit_idx, e_idx);
        check({pfx, "sdata"}, sdata, e_sdata);
        if (e_wr) begin
          check({pfx, "in_bit_idx"}, in_bit_idx, CB - 1 - j);
          check({pfx, "in_bits"}, in_bits, (D == 1) ? lim_tab[0] : lim_tab[CB - 1 - j]);
        end
      end
      if (in_bitz && sub == 0) e_sdata = out_tab[CB - 1 - j];

      // Inputs visible now are sampled at the next rising edge.
      if (reset) begin
        fstart  = -1;
        pend    = 0;
        ovr     = 0;
        e_sdata = '0;
        e_idx   = CB - 1;
        armed   = 1;
      end else if (armed) begin
        last    = e_busy && (rel == L - 1);
        ovr_set = 0;
        if (e_busy && !last) begin
          if (frame_req) begin
            if (pend) ovr_set = 1;
            else      pend    = 1;
          end
        end else if (last) begin
          fstart = (enable && (frame_req || pend)) ? cyc + 1 : -1;
          pend   = 0;
        end else if (enable && frame_req) begin
          fstart = cyc + 1;
        end
        if (ovr_set)          ovr = 1;
        else if (overrun_clr) ovr = 0;
      end
      cyc++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_req();
    frame_req = 1'b1;
    cycles(1);
    frame_req = 1'b0;
  endtask

  task automatic new_tables();
    for (int i = 0; i < CB; i++) begin
      out_tab[i]    = OL'($urandom);
      out_tab[i][0] = i[0];
      lim_tab[i]    = IL'($urandom);
    end
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    frame_req   = 1'b0;
    overrun_clr = 1'b0;
    for (int i = 0; i < CB; i++) begin
      out_tab[i] = 24'hA5A5A5;
      lim_tab[i] = IL'($urandom);
    end
    cycles(3);
    reset  = 1'b0;
    enable = 1'b1;

    // Single frame with a constant pattern.
    pulse_req();
    cycles(150);

    // Idx-dependent data, one pending request and one lost request.
    new_tables();
    pulse_req();
    cycles(10);
    pulse_req();
    cycles(10);
    pulse_req();
    cycles(300);
    overrun_clr = 1'b1;
    cycles(1);
    overrun_clr = 1'b0;
    cycles(5);

    // Reset in the middle of a frame.
    pulse_req();
    cycles(49);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    cycles(5);

    // enable dropped while a request is pending.
    pulse_req();
    cycles(5);
    pulse_req();
    cycles(5);
    enable = 1'b0;
    cycles(20);
    pulse_req();
    cycles(300);
    enable = 1'b1;
    new_tables();
    cycles(2);

    for (int n = 0; n < 8000; n++) begin
      frame_req   = ($urandom_range(0, 29) == 0);
      overrun_clr = ($urandom_range(0, 49) == 0);
      reset       = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      cycles(1);
    end
    frame_req   = 1'b0;
    overrun_clr = 1'b0;
    reset       = 1'b0;
    cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
